// File: rtl/load_align_unit.sv
// Load path between MEM stage and data memory: issues word-aligned reads, merges straddling
// loads from two words, then extracts and sign/zero-extends the result per funct3.
module load_align_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    StIdle, StIssue0, StWait0, StIssue1, StWait1, StResp
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [OFF_W-1:0]  off_q;
  logic              span_q;
  logic [ADDR_W-1:0] aligned_addr;

  function automatic logic f3_legal(input logic [2:0] f);
    case (f)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      3'b011, 3'b110:                         return DATA_W == 64;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic f3_span(input logic [OFF_W-1:0] off, input logic [2:0] f);
    int unsigned sum;
    sum = 32'(off) + (32'd1 << f[1:0]);
    return sum > BYTES;
  endfunction

  // Shift the {hi,lo} pair down to the byte offset, keep size bytes, then extend.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] hi,
                                                input logic [DATA_W-1:0] lo,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [2:0]        f);
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] mask;
    logic              sgn_bit;
    int                nb;
    raw = DATA_W'({hi, lo} >> {off, 3'b000});
    nb  = 1 << f[1:0];
    for (int i = 0; i < int'(BYTES); i++) begin
      mask[8*i +: 8] = (i < nb) ? 8'hFF : 8'h00;
    end
    case (f[1:0])
      2'b00:   sgn_bit = raw[7];
      2'b01:   sgn_bit = raw[15];
      2'b10:   sgn_bit = raw[31];
      default: sgn_bit = raw[DATA_W-1];
    endcase
    // Full-width loads have an all-ones mask, so they come back unchanged.
    return (raw & mask) | ((~f[2] & sgn_bit) ? ~mask : '0);
  endfunction

  assign off_q        = addr_q[OFF_W-1:0];
  assign span_q       = f3_span(off_q, funct3_q);
  assign aligned_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    lo_d       = lo_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          if (!f3_legal(req_funct3) ||
              (!MISALIGN_EN && f3_span(req_addr[OFF_W-1:0], req_funct3))) begin
            state_d    = StResp;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d = StIssue0;
          end
        end
      end
      StIssue0: begin
        mem_req  = 1'b1;
        mem_addr = aligned_addr;
        state_d  = StWait0;
      end
      StWait0: begin
        if (mem_rvalid) begin
          lo_d = mem_rdata;
          if (span_q) begin
            state_d = StIssue1;
          end else begin
            state_d    = StResp;
            rsp_err_d  = 1'b0;
            rsp_data_d = extract('0, mem_rdata, off_q, funct3_q);
          end
        end
      end
      StIssue1: begin
        mem_req  = 1'b1;
        mem_addr = aligned_addr + ADDR_W'(BYTES);
        state_d  = StWait1;
      end
      StWait1: begin
        if (mem_rvalid) begin
          state_d    = StResp;
          rsp_err_d  = 1'b0;
          rsp_data_d = extract(mem_rdata, lo_q, off_q, funct3_q);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d    = StIdle;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      funct3_q   <= '0;
      lo_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      lo_q       <= lo_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
